// File: rtl/caliptra_prim_blank_sequencer_pkg.sv
// ============================================================================
// Module : caliptra_prim_blank_sequencer_pkg
// Brief  : Shared types and helpers for the blanker enable sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package caliptra_prim_blank_sequencer_pkg;

    localparam int unsigned StateW = 6;

    // Pairwise Hamming distance >= 3 so a single upset never lands on a legal state.
    typedef enum logic [StateW-1:0] {
        IDLE    = 6'b000000,
        SETUP   = 6'b000111,
        OPEN    = 6'b011001,
        HOLDOFF = 6'b101010,
        ERROR   = 6'b110100
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/caliptra_prim_blank_rr_pick.sv
// ============================================================================
// Module : caliptra_prim_blank_rr_pick
// Brief  : Combinational round-robin picker: first eligible index at/after ptr.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module caliptra_prim_blank_rr_pick
    import caliptra_prim_blank_sequencer_pkg::*;
#(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] eligible_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [2*NumReq-1:0] w_dbl;
    logic [NumReq-1:0]   w_rot;
    logic [IdxW-1:0]     w_off;
    logic [IdxW:0]       w_sum;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit then wins.
    assign w_dbl = {eligible_i, eligible_i};
    assign w_rot = NumReq'(w_dbl >> ptr_i);

    always_comb begin
        w_off = '0;
        for (int j = NumReq - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IdxW'(j);
            end
        end
    end

    assign w_sum   = {1'b0, ptr_i} + {1'b0, w_off};
    assign idx_o   = (w_sum >= (IdxW+1)'(NumReq)) ? IdxW'(w_sum - (IdxW+1)'(NumReq))
                                                  : w_sum[IdxW-1:0];
    assign valid_o = |eligible_i;

endmodule

`default_nettype wire

// File: rtl/caliptra_prim_blank_sequencer.sv
// ============================================================================
// Module : caliptra_prim_blank_sequencer
// Brief  : Round-robin arbiter sequencing a blanker enable with settle,
//          maximum-open and holdoff timing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module caliptra_prim_blank_sequencer
    import caliptra_prim_blank_sequencer_pkg::*;
#(
    parameter  int unsigned NumReq        = 2,
    parameter  int unsigned SetupCycles   = 2,
    parameter  int unsigned MaxOpenCycles = 16,
    parameter  int unsigned HoldoffCycles = 1,
    localparam int unsigned IdxW          = idx_width(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   sel_o,
    output logic              en_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic              err_o
);

    localparam int unsigned MaxSh  = (SetupCycles > MaxOpenCycles) ? SetupCycles : MaxOpenCycles;
    localparam int unsigned MaxCnt = (MaxSh > HoldoffCycles) ? MaxSh : HoldoffCycles;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] SetupLd = CntW'(SetupCycles - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(HoldoffCycles - 1);
    localparam logic [CntW-1:0] OpenLd  = (MaxOpenCycles == 0) ? '0 : CntW'(MaxOpenCycles - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumReq-1:0]   mask_q, mask_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     sel_q, sel_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic                err_q, err_d;

    logic                pick_valid;
    logic [IdxW-1:0]     pick_idx;
    logic                req_sel;
    logic [IdxW-1:0]     ptr_after_sel;
    logic [NumReq-1:0]   gnt_sel;

    caliptra_prim_blank_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .eligible_i (req_i & ~mask_q),
        .ptr_i      (ptr_q),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    assign req_sel       = req_i[sel_q];
    assign ptr_after_sel = (sel_q == IdxW'(NumReq - 1)) ? '0 : sel_q + IdxW'(1);
    assign gnt_sel       = {{(NumReq-1){1'b0}}, 1'b1} << sel_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        mask_d    = mask_q & req_i;
        gnt_d     = '0;
        en_d      = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SETUP;
                    sel_d   = pick_idx;
                    cnt_d   = SetupLd;
                end
            end
            SETUP: begin
                if (!req_sel) begin
                    state_d = HOLDOFF;
                    cnt_d   = HoldLd;
                    ptr_d   = ptr_after_sel;
                end else if (cnt_q == '0) begin
                    state_d = OPEN;
                    cnt_d   = OpenLd;
                    en_d    = 1'b1;
                    gnt_d   = gnt_sel;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            OPEN: begin
                // A drop outranks an expiry in the same cycle: no pulse, no mask.
                if (!req_sel) begin
                    state_d = HOLDOFF;
                    cnt_d   = HoldLd;
                    ptr_d   = ptr_after_sel;
                end else if (MaxOpenCycles != 0 && cnt_q == '0) begin
                    state_d        = HOLDOFF;
                    cnt_d          = HoldLd;
                    ptr_d          = ptr_after_sel;
                    timeout_d      = 1'b1;
                    mask_d[sel_q]  = 1'b1;
                end else begin
                    en_d  = 1'b1;
                    gnt_d = gnt_sel;
                    if (MaxOpenCycles != 0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        busy_d = (state_d != IDLE);
        err_d  = (state_d == ERROR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign en_o      = en_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
    assign err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_caliptra_prim_blank_sequencer.sv
// ============================================================================
// Module : tb_caliptra_prim_blank_sequencer
// Brief  : Self-checking bench against a timestamp-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_caliptra_prim_blank_sequencer;

    localparam int NR   = 2;
    localparam int SET  = 2;
    localparam int MAXO = 16;
    localparam int HOLD = 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [NR-1:0] req_i = '0;
    logic [NR-1:0] gnt_o;
    logic [0:0]    sel_o;
    logic          en_o, busy_o, timeout_o, err_o;
    logic [6:0]    obs;

    int n_checks = 0;
    int n_fail   = 0;

    caliptra_prim_blank_sequencer #(
        .NumReq        (NR),
        .SetupCycles   (SET),
        .MaxOpenCycles (MAXO),
        .HoldoffCycles (HOLD)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .sel_o     (sel_o),
        .en_o      (en_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    assign obs = {en_o, gnt_o, sel_o, busy_o, timeout_o, err_o};

    // Reference model: a grant is described by the edge it was sampled on (m_t0)
    // and a holdoff by the edge it began on (m_h0); phases follow from elapsed edges.
    int            cyc;
    bit            m_act, m_hold, m_en, m_to, m_busy;
    int            m_t0, m_h0, m_win, m_sel, m_ptr;
    logic [NR-1:0] m_mask;

    task automatic model_reset();
        cyc = 0; m_act = 0; m_hold = 0; m_en = 0; m_to = 0; m_busy = 0;
        m_t0 = 0; m_h0 = 0; m_win = 0; m_sel = 0; m_ptr = 0; m_mask = '0;
    endtask

    task automatic model_edge(input logic [NR-1:0] r);
        logic [NR-1:0] newmask, el;
        int e;
        bit found;
        cyc++;
        m_en = 0; m_to = 0;
        newmask = m_mask & r;
        if (m_act) begin
            e = cyc - m_t0;
            if (!r[m_win] || (e >= SET && MAXO != 0 && e - SET == MAXO)) begin
                if (r[m_win]) begin
                    m_to = 1;
                    newmask[m_win] = 1'b1;
                end
                m_act = 0; m_hold = 1; m_h0 = cyc; m_ptr = (m_win + 1) % NR;
            end else if (e >= SET) begin
                m_en = 1;
            end
        end else if (m_hold) begin
            if (cyc - m_h0 == HOLD) m_hold = 0;
        end else begin
            el = r & ~m_mask;
            found = 0;
            for (int j = 0; j < NR; j++) begin
                int i;
                i = (m_ptr + j) % NR;
                if (!found && el[i]) begin
                    found = 1; m_win = i; m_sel = i; m_t0 = cyc; m_act = 1;
                end
            end
        end
        m_mask = newmask;
        m_busy = m_act | m_hold;
    endtask

    function automatic logic [6:0] exp_vec();
        logic [NR-1:0] g;
        g = m_en ? (NR'(1) << m_win) : '0;
        return {m_en, g, 1'(m_sel), m_busy, m_to, 1'b0};
    endfunction

    task automatic step(input logic [NR-1:0] r);
        req_i = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        req_i = '0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // Structural invariants, sampled on the falling edge.
    logic prev_en = 1'b0;
    logic [0:0] prev_sel = '0;
    always @(negedge clk) begin
        if (!rst_i) begin
            n_checks++;
            if ((en_o !== |gnt_o) || !$onehot0(gnt_o) || (en_o && prev_en && sel_o !== prev_sel)) begin
                n_fail++;
                $display("FAIL invariant t=%0t: en=%b gnt=%b sel=%b prev_sel=%b", $time, en_o, gnt_o, sel_o, prev_sel);
            end
            prev_en  <= en_o;
            prev_sel <= sel_o;
        end else begin
            prev_en <= 1'b0;
        end
    end

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs, 7'b0);
        end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int first_en, en_cnt, to_cnt;
        reset_dut();
        first_en = -1; en_cnt = 0; to_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step((i < 20) ? 2'b01 : 2'b00);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL single step %0d: got %b want %b", i, obs, exp_vec());
            end
            if (en_o === 1'b1 && first_en < 0) first_en = i;
            if (en_o === 1'b1) en_cnt++;
            if (timeout_o === 1'b1) to_cnt++;
        end
        n_checks++;
        if (first_en != SET) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first_en, SET); end
        n_checks++;
        if (en_cnt != MAXO) begin n_fail++; $display("FAIL single_open_len: got %0d want %0d", en_cnt, MAXO); end
        n_checks++;
        if (to_cnt != 1) begin n_fail++; $display("FAIL single_timeout_pulses: got %0d want 1", to_cnt); end
    endtask

    task automatic test_rerequest();
        int k, late_en, regrant;
        reset_dut();
        k = $urandom_range(3, 12);
        late_en = 0; regrant = 0;
        for (int i = 0; i < 19 + k + 5; i++) begin
            logic [NR-1:0] r;
            r = (i == 19 + k) ? 2'b00 : 2'b01;
            step(r);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rerequest step %0d: got %b want %b", i, obs, exp_vec());
            end
            if (i > 18 && i <= 19 + k && en_o === 1'b1) late_en++;
            if (i > 19 + k && en_o === 1'b1) regrant = 1;
        end
        n_checks++;
        if (late_en != 0) begin n_fail++; $display("FAIL rerequest_masked: got %0d en cycles want 0", late_en); end
        n_checks++;
        if (regrant != 1) begin n_fail++; $display("FAIL rerequest_regrant: got %0d want 1", regrant); end
    endtask

    task automatic test_round_robin();
        int oc, ng;
        int grants[4];
        bit pen;
        logic [NR-1:0] r;
        reset_dut();
        oc = 0; ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            r = 2'b11;
            if (oc == 3) begin r[m_win] = 1'b0; oc = 0; end
            pen = m_en;
            step(r);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL round_robin step %0d: got %b want %b", i, obs, exp_vec());
            end
            if (en_o === 1'b1 && !pen) begin grants[ng] = int'(sel_o); ng++; end
            if (m_en) oc++;
        end
        n_checks++;
        if (ng != 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 4", ng); end
        for (int g = 0; g < ng; g++) begin
            n_checks++;
            if (grants[g] != g % 2) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", g, grants[g], g % 2);
            end
        end
    endtask

    task automatic test_drop_setup();
        int w, bad;
        reset_dut();
        w = $urandom_range(0, 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step((i == 0) ? (NR'(1) << w) : 2'b00);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL drop_setup step %0d: got %b want %b", i, obs, exp_vec());
            end
            if (en_o === 1'b1 || timeout_o === 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_setup_quiet: got bad=%0d busy=%b want bad=0 busy=0", bad, busy_o);
        end
    endtask

    task automatic test_drop_timeout();
        int to_cnt, regrant;
        reset_dut();
        to_cnt = 0; regrant = 0;
        for (int i = 0; i < 24; i++) begin
            step((i == SET + MAXO) ? 2'b00 : 2'b01);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL drop_timeout step %0d: got %b want %b", i, obs, exp_vec());
            end
            if (timeout_o === 1'b1) to_cnt++;
            if (i > SET + MAXO && en_o === 1'b1) regrant = 1;
        end
        n_checks++;
        if (to_cnt != 0) begin n_fail++; $display("FAIL drop_timeout_pulse: got %0d want 0", to_cnt); end
        n_checks++;
        if (regrant != 1) begin n_fail++; $display("FAIL drop_timeout_unmasked: got %0d want 1", regrant); end
    endtask

    task automatic test_random();
        logic [NR-1:0] r;
        reset_dut();
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) r = NR'($urandom);
            step(r);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random step %0d req=%b: got %b want %b", i, r, obs, exp_vec());
            end
        end
    endtask

    task automatic test_fault();
        reset_dut();
        for (int i = 0; i < 3; i++) step(2'b10);
        n_checks++;
        if (obs !== exp_vec() || en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_preopen: got %b want %b", obs, exp_vec());
        end
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, 7'b0); end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();

        force dut.state_q = caliptra_prim_blank_sequencer_pkg::state_e'(6'h3f);
        step(2'b00);
        release dut.state_q;
        for (int i = 0; i < 6; i++) begin
            step(NR'($urandom));
            n_checks++;
            if (err_o !== 1'b1 || en_o !== 1'b0 || gnt_o !== '0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_error step %0d: got err=%b en=%b gnt=%b busy=%b want 1 0 00 1", i, err_o, en_o, gnt_o, busy_o);
            end
        end
        reset_dut();
        n_checks++;
        if (obs !== 7'b0) begin n_fail++; $display("FAIL fault_cleared: got %b want %b", obs, 7'b0); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rerequest();
        test_round_robin();
        test_drop_setup();
        test_drop_timeout();
        test_random();
        test_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
